// File: rtl/core_pkg.sv
// core_pkg: shared types and default constants for the core_s control sequencer.
//   seq_state_t : sequencer states
//   WDT_W_DEF   : default watchdog counter width
//   XLEN_DEF    : default width of the retired-instruction counter
package core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    HALT
  } seq_state_t;

  localparam int WDT_W_DEF = 8;
  localparam int XLEN_DEF  = 32;

endpackage

// File: rtl/core_seq_if.sv
// core_seq_if: bundles the sequencer's bus handshakes, decode flags and datapath
// write enables.
//   master : sequencer side (drives requests, write enables, status)
//   slave  : IFU/LSU/IDU/EXU side (drives rvalids and decode flags)
// Signals:
//   ifu_req/ifu_rvalid      instruction fetch handshake
//   lsu_req/lsu_rvalid      load/store handshake
//   ir_we, rf_we, pc_we     one-cycle datapath write enables
//   dec_*                   decode flags for the instruction held in IR
//   halted, bus_timeout     sticky stop status
//   retire_cnt              retired instruction count
interface core_seq_if
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) ();

  logic            ifu_req;
  logic            ifu_rvalid;
  logic            ir_we;
  logic            dec_mem_read;
  logic            dec_mem_write;
  logic            dec_rd_write;
  logic            dec_ebreak;
  logic            lsu_req;
  logic            lsu_rvalid;
  logic            rf_we;
  logic            pc_we;
  logic            halted;
  logic            bus_timeout;
  logic [XLEN-1:0] retire_cnt;

  modport master (
    output ifu_req, ir_we, lsu_req, rf_we, pc_we, halted, bus_timeout, retire_cnt,
    input  ifu_rvalid, lsu_rvalid, dec_mem_read, dec_mem_write, dec_rd_write, dec_ebreak
  );

  modport slave (
    input  ifu_req, ir_we, lsu_req, rf_we, pc_we, halted, bus_timeout, retire_cnt,
    output ifu_rvalid, lsu_rvalid, dec_mem_read, dec_mem_write, dec_rd_write, dec_ebreak
  );

endinterface

// File: rtl/core_seq_wdt.sv
// core_seq_wdt: bus watchdog counter.
//   clk, rst_b : clock, async active-low reset
//   clr        : zero the count (priority over en)
//   en         : this cycle is a waiting cycle; count it
//   tc         : this waiting cycle is the (2^WDT_W-1)-th in a row
module core_seq_wdt
  import core_pkg::*;
#(
  parameter int WDT_W = WDT_W_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WDT_W-1:0] ONE       = WDT_W'(1);
  // cnt holds the number of waiting cycles already completed, so the cycle
  // seen with cnt == all-ones minus one is the one that reaches the limit.
  localparam logic [WDT_W-1:0] LAST_WAIT = {WDT_W{1'b1}} - ONE;

  logic [WDT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

  assign tc = en && (cnt == LAST_WAIT);

endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle control sequencer for the pipeline-less core_s core.
// Steps each instruction through fetch, execute, optional memory access and
// retire, with a bus watchdog and a retired-instruction counter.
//   clk   : core clock
//   rst_b : async active-low reset
//   start : begin execution (only looked at in IDLE)
//   bus   : core_seq_if master modport (handshakes, decode flags, enables, status)
//
// state | meaning
// IDLE  | waiting for start, no requests
// FETCH | ifu_req high, waiting for ifu_rvalid
// EXEC  | IR stable, decode/execute settle, retire ALU/ebreak
// MEM   | lsu_req high, waiting for lsu_rvalid, retire load/store
// HALT  | stopped until reset (ebreak or bus timeout)
module core_seq
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int WDT_W  = WDT_W_DEF,
  parameter bit WDT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  core_seq_if.master  bus
);

  seq_state_t      state;
  logic            ifu_req_q;
  logic            lsu_req_q;
  logic            halted_q;
  logic            bus_timeout_q;
  logic [XLEN-1:0] retire_q;

  logic is_mem;
  logic exec_alu;
  logic mem_done;
  logic waiting;
  logic wdt_en;
  logic wdt_clr;
  logic wdt_tc;

  assign is_mem   = bus.dec_mem_read | bus.dec_mem_write;
  assign exec_alu = (state == EXEC) && !bus.dec_ebreak && !is_mem;
  assign mem_done = (state == MEM) && bus.lsu_rvalid;

  // Every FETCH/MEM cycle without its rvalid is a waiting cycle; any other cycle
  // clears the count, which covers clearing on entry to FETCH and MEM.
  assign waiting = ((state == FETCH) && !bus.ifu_rvalid) ||
                   ((state == MEM)   && !bus.lsu_rvalid);
  assign wdt_en  = WDT_EN && waiting;
  assign wdt_clr = !WDT_EN || !waiting;

  core_seq_wdt #(.WDT_W(WDT_W)) u_wdt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (wdt_clr),
    .en    (wdt_en),
    .tc    (wdt_tc)
  );

  // Moore outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      ifu_req_q     <= 1'b0;
      lsu_req_q     <= 1'b0;
      halted_q      <= 1'b0;
      bus_timeout_q <= 1'b0;
      retire_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            ifu_req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.ifu_rvalid) begin
            state     <= EXEC;
            ifu_req_q <= 1'b0;
          end else if (wdt_tc) begin
            state         <= HALT;
            ifu_req_q     <= 1'b0;
            halted_q      <= 1'b1;
            bus_timeout_q <= 1'b1;
          end
        end
        EXEC: begin
          if (bus.dec_ebreak) begin
            state    <= HALT;
            halted_q <= 1'b1;
            retire_q <= retire_q + XLEN'(1);
          end else if (is_mem) begin
            state     <= MEM;
            lsu_req_q <= 1'b1;
          end else begin
            state     <= FETCH;
            ifu_req_q <= 1'b1;
            retire_q  <= retire_q + XLEN'(1);
          end
        end
        MEM: begin
          if (bus.lsu_rvalid) begin
            state     <= FETCH;
            lsu_req_q <= 1'b0;
            ifu_req_q <= 1'b1;
            retire_q  <= retire_q + XLEN'(1);
          end else if (wdt_tc) begin
            state         <= HALT;
            lsu_req_q     <= 1'b0;
            halted_q      <= 1'b1;
            bus_timeout_q <= 1'b1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state         <= IDLE;
          ifu_req_q     <= 1'b0;
          lsu_req_q     <= 1'b0;
          halted_q      <= 1'b0;
          bus_timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ifu_req     = ifu_req_q;
  assign bus.lsu_req     = lsu_req_q;
  assign bus.halted      = halted_q;
  assign bus.bus_timeout = bus_timeout_q;
  assign bus.retire_cnt  = retire_q;

  // Write enables are one-cycle Mealy pulses in the handshake/retire cycle.
  // A load with the write flag also set still writes rd; a store never does.
  assign bus.ir_we = (state == FETCH) && bus.ifu_rvalid;
  assign bus.rf_we = (exec_alu && bus.dec_rd_write) || (mem_done && bus.dec_mem_read);
  assign bus.pc_we = exec_alu || mem_done;

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;

  localparam int XW        = 4;
  localparam int WW        = 4;
  localparam int WDT_LIMIT = (1 << WW) - 1;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  logic start = 1'b0;

  core_seq_if #(.XLEN(XW)) bus ();

  core_seq #(.XLEN(XW), .WDT_W(WW), .WDT_EN(1'b1)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what the core is doing, how long it has waited on
  // the bus, and how many instructions it has retired.
  typedef enum int {M_IDLE, M_FETCH, M_EXEC, M_MEM, M_HALT} mphase_t;
  mphase_t m_ph      = M_IDLE;
  int      m_waited  = 0;
  int      m_retired = 0;
  bit      m_to      = 1'b0;

  always @(negedge clk) begin
    bit is_mem, alu, mdone, e_rf, e_pc, e_ir;
    if (!rst_b) begin
      m_ph = M_IDLE; m_waited = 0; m_retired = 0; m_to = 1'b0;
      check("rst_outputs", {bus.ifu_req, bus.lsu_req, bus.ir_we, bus.rf_we,
                            bus.pc_we, bus.halted, bus.bus_timeout}, 0);
      check("rst_retire", bus.retire_cnt, 0);
    end else begin
      is_mem = bus.dec_mem_read || bus.dec_mem_write;
      alu    = (m_ph == M_EXEC) && !bus.dec_ebreak && !is_mem;
      mdone  = (m_ph == M_MEM) && bus.lsu_rvalid;
      e_ir   = (m_ph == M_FETCH) && bus.ifu_rvalid;
      e_rf   = (alu && bus.dec_rd_write) || (mdone && bus.dec_mem_read);
      e_pc   = alu || mdone;
      check("m_ifu_req", bus.ifu_req, m_ph == M_FETCH);
      check("m_lsu_req", bus.lsu_req, m_ph == M_MEM);
      check("m_halted", bus.halted, m_ph == M_HALT);
      check("m_bus_timeout", bus.bus_timeout, m_to);
      check("m_retire_cnt", bus.retire_cnt, m_retired);
      check("m_ir_we", bus.ir_we, e_ir);
      check("m_rf_we", bus.rf_we, e_rf);
      check("m_pc_we", bus.pc_we, e_pc);
      case (m_ph)
        M_IDLE: if (start) begin m_ph = M_FETCH; m_waited = 0; end
        M_FETCH, M_MEM: begin
          if ((m_ph == M_FETCH) ? bus.ifu_rvalid : bus.lsu_rvalid) begin
            if (m_ph == M_MEM) begin
              m_retired = (m_retired + 1) % (1 << XW);
              m_ph = M_FETCH; m_waited = 0;
            end else m_ph = M_EXEC;
          end else begin
            m_waited++;
            if (m_waited == WDT_LIMIT) begin m_ph = M_HALT; m_to = 1'b1; end
          end
        end
        M_EXEC: begin
          if (bus.dec_ebreak) begin
            m_retired = (m_retired + 1) % (1 << XW);
            m_ph = M_HALT;
          end else if (is_mem) begin
            m_ph = M_MEM; m_waited = 0;
          end else begin
            m_retired = (m_retired + 1) % (1 << XW);
            m_ph = M_FETCH; m_waited = 0;
          end
        end
        default: m_ph = M_HALT;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    start             = 1'b0;
    bus.ifu_rvalid    = 1'b0;
    bus.lsu_rvalid    = 1'b0;
    bus.dec_mem_read  = 1'b0;
    bus.dec_mem_write = 1'b0;
    bus.dec_rd_write  = 1'b0;
    bus.dec_ebreak    = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    zero_inputs();
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From FETCH: zero-wait fetch, then one EXEC cycle with the given decode.
  task automatic instr(input bit mr, input bit mw, input bit rd, input bit eb);
    bus.dec_mem_read  = mr;
    bus.dec_mem_write = mw;
    bus.dec_rd_write  = rd;
    bus.dec_ebreak    = eb;
    bus.ifu_rvalid    = 1'b1;
    #1 check("instr_ir_we", bus.ir_we, 1);
    tick();
    bus.ifu_rvalid = 1'b0;
    tick();
  endtask

  initial begin
    int req_cycles;
    int wcnt;
    int p_if, p_lsu, rst_at;
    zero_inputs();
    rst_b = 1'b0;
    #3;
    check("reset_ifu_req", bus.ifu_req, 0);
    check("reset_halted", bus.halted, 0);
    check("reset_retire", bus.retire_cnt, 0);
    tick();
    tick();
    rst_b = 1'b1;

    // ALU addi, zero-wait fetch
    go();
    check("t1_ifu_req_cycle1", bus.ifu_req, 1);
    bus.dec_rd_write = 1'b1;
    bus.ifu_rvalid   = 1'b1;
    #1 check("t1_ir_we", bus.ir_we, 1);
    tick();
    bus.ifu_rvalid = 1'b0;
    #1 check("t1_rf_we", bus.rf_we, 1);
    check("t1_pc_we", bus.pc_we, 1);
    check("t1_exec_ifu_req", bus.ifu_req, 0);
    tick();
    check("t1_retire", bus.retire_cnt, 1);
    check("t1_back_fetch", bus.ifu_req, 1);
    check("t1_rf_we_off", bus.rf_we, 0);

    // load with lsu_rvalid five cycles late
    bus.dec_rd_write = 1'b0;
    bus.dec_mem_read = 1'b1;
    bus.ifu_rvalid   = 1'b1;
    tick();
    bus.ifu_rvalid = 1'b0;
    #1 check("ld_exec_pc_we", bus.pc_we, 0);
    check("ld_exec_rf_we", bus.rf_we, 0);
    tick();
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      bus.lsu_rvalid = (i == 5);
      #1;
      if (bus.lsu_req) req_cycles++;
      check("ld_rf_we", bus.rf_we, (i == 5));
      check("ld_pc_we", bus.pc_we, (i == 5));
      tick();
    end
    bus.lsu_rvalid = 1'b0;
    check("ld_req_cycles", req_cycles, 6);
    check("ld_retire", bus.retire_cnt, 2);
    check("ld_back_fetch", bus.ifu_req, 1);

    // store, even with rd_write set, never writes the register file
    instr(1'b0, 1'b1, 1'b1, 1'b0);
    bus.lsu_rvalid = 1'b1;
    #1 check("st_pc_we", bus.pc_we, 1);
    check("st_rf_we", bus.rf_we, 0);
    tick();
    bus.lsu_rvalid = 1'b0;
    check("st_retire", bus.retire_cnt, 3);

    // read and write both set behaves as a load
    instr(1'b1, 1'b1, 1'b0, 1'b0);
    bus.lsu_rvalid = 1'b1;
    #1 check("rw_rf_we", bus.rf_we, 1);
    tick();
    bus.lsu_rvalid = 1'b0;
    check("rw_retire", bus.retire_cnt, 4);

    // three ALU ops then ebreak
    do_reset();
    go();
    for (int i = 0; i < 3; i++) instr(1'b0, 1'b0, 1'b1, 1'b0);
    instr(1'b0, 1'b0, 1'b0, 1'b1);
    check("eb_halted", bus.halted, 1);
    check("eb_retire", bus.retire_cnt, 4);
    check("eb_timeout", bus.bus_timeout, 0);
    bus.dec_ebreak = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start          = i[0];
      bus.ifu_rvalid = 1'b1;
      #1 check("eb_ifu_req_low", bus.ifu_req, 0);
      check("eb_stays_halted", bus.halted, 1);
      tick();
    end
    zero_inputs();

    // fetch that never completes
    do_reset();
    go();
    wcnt = 0;
    for (int i = 0; i < 40 && bus.ifu_req; i++) begin
      wcnt++;
      tick();
    end
    check("wdt_wait_cycles", wcnt, WDT_LIMIT);
    check("wdt_halted", bus.halted, 1);
    check("wdt_bus_timeout", bus.bus_timeout, 1);

    // rvalid in the last allowed cycle wins
    do_reset();
    go();
    for (int i = 0; i < WDT_LIMIT; i++) begin
      bus.ifu_rvalid = (i == WDT_LIMIT - 1);
      #1 check("late_ifu_req", bus.ifu_req, 1);
      tick();
    end
    bus.ifu_rvalid = 1'b0;
    #1 check("late_halted", bus.halted, 0);
    check("late_bus_timeout", bus.bus_timeout, 0);
    check("late_exec_pc_we", bus.pc_we, 1);
    tick();
    check("late_back_fetch", bus.ifu_req, 1);

    // retire counter wrap, then async reset mid-MEM
    do_reset();
    go();
    for (int i = 0; i < 15; i++) instr(1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_15", bus.retire_cnt, 15);
    instr(1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_0", bus.retire_cnt, 0);
    instr(1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_1", bus.retire_cnt, 1);
    instr(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    #1 check("mid_mem_lsu_req", bus.lsu_req, 1);
    #2 rst_b = 1'b0;
    #1 check("arst_lsu_req", bus.lsu_req, 0);
    check("arst_ifu_req", bus.ifu_req, 0);
    check("arst_halted", bus.halted, 0);
    check("arst_retire", bus.retire_cnt, 0);
    zero_inputs();
    tick();
    rst_b = 1'b1;

    // randomized episodes against the model
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      case ($urandom_range(0, 3))
        0: p_if = 100;
        1: p_if = 70;
        2: p_if = 30;
        default: p_if = 0;
      endcase
      p_lsu  = (ep % 5 == 4) ? 0 : $urandom_range(20, 100);
      rst_at = $urandom_range(0, 399);
      for (int c = 0; c < 200; c++) begin
        rst_b             = (c != rst_at);
        start             = ($urandom_range(0, 3) == 0);
        bus.ifu_rvalid    = ($urandom_range(0, 99) < p_if);
        bus.lsu_rvalid    = ($urandom_range(0, 99) < p_lsu);
        bus.dec_mem_read  = ($urandom_range(0, 3) == 0);
        bus.dec_mem_write = ($urandom_range(0, 3) == 0);
        bus.dec_rd_write  = $urandom_range(0, 1);
        bus.dec_ebreak    = ($urandom_range(0, 24) == 0);
        tick();
      end
    end

    rst_b = 1'b1;
    zero_inputs();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL tb_time_limit: simulation did not complete at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
